// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with 16x oversampling and a first-word-fall-through
// receive FIFO exposing a valid/ready read port.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rx_sig            asynchronous serial input (idle high)
//   baud_div          clocks per oversample tick (0 selects the parameter default)
//   rx_data,
//   rx_parity_err,
//   rx_frame_err      head-of-FIFO entry
//   rx_valid/rx_ready read handshake (pop when both high)
//   fifo_count        current occupancy
//   overrun           sticky frame-dropped flag, cleared by overrun_clr
//   break_det         one-cycle pulse when a break frame is pushed
//
// Build option: define UART_RX_MAJORITY_EN to decide each bit (including the
// start-bit glitch check) by 2-of-3 majority of ticks 6/7/8, taken at tick 8.
// Without it, a single sample at tick 7 is used.
module uart_rx_fifo #(
  parameter int ClockFreqHz = 10000000,
  parameter int BaudRate    = 9600,
  parameter int DataBits    = 8,
  parameter int ParityMode  = 0,
  parameter int StopBits    = 1,
  parameter int FifoDepth   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_sig,
  input  logic [15:0]                  baud_div,
  output logic [DataBits-1:0]          rx_data,
  output logic                         rx_parity_err,
  output logic                         rx_frame_err,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FifoDepth):0]   fifo_count,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic                         break_det
);

  localparam int          AW        = $clog2(FifoDepth);
  localparam int          CW        = AW + 1;
  localparam int          EW        = DataBits + 2;
  localparam logic [15:0] DefDiv    = 16'(ClockFreqHz / (BaudRate * 16));
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0]  SampTick  = 4'd8;
`else
  localparam logic [3:0]  SampTick  = 4'd7;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [15:0]          div_q, tcnt_q;
  logic [3:0]           scnt_q;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [DataBits-1:0]  shreg_q, shreg_d;
  logic                 perr_q, perr_d, pbit_q, pbit_d, ferr_q, ferr_d;
  logic                 brk_q;
  logic                 tick, samp, last, bit_s, push, brk;

  assign tick = (tcnt_q == div_q - 16'd1);
  assign samp = tick && (scnt_q == SampTick);
  assign last = tick && (scnt_q == 4'd15);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      maj_q <= 2'b11;
    end else if (tick && scnt_q == 4'd6) begin
      maj_q[0] <= sync2_q;
    end else if (tick && scnt_q == 4'd7) begin
      maj_q[1] <= sync2_q;
    end
  end
  assign bit_s = (maj_q[0] & maj_q[1]) | (maj_q[0] & sync2_q) | (maj_q[1] & sync2_q);
`else
  assign bit_s = sync2_q;
`endif

  // Synchroniser, baud divisor latch and oversample counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      div_q   <= DefDiv;
      tcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      sync1_q <= rx_sig;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (state_q == IDLE) begin
        // Divisor only changes between frames; counters are parked at zero
        // so the start edge begins a clean bit period.
        div_q  <= (baud_div == 16'd0) ? DefDiv : baud_div;
        tcnt_q <= '0;
        scnt_q <= '0;
      end else begin
        tcnt_q <= tick ? 16'd0 : tcnt_q + 16'd1;
        if (tick) scnt_q <= scnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      perr_q   <= 1'b0;
      pbit_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      perr_q   <= perr_d;
      pbit_q   <= pbit_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    pbit_d   = pbit_q;
    ferr_d   = ferr_q;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d  = START;
          bitcnt_d = '0;
          perr_d   = 1'b0;
          pbit_d   = 1'b0;
          ferr_d   = 1'b0;
        end
      end
      START: begin
        if (samp && bit_s) state_d = IDLE;   // line back high: glitch
        else if (last)     state_d = DATA;
      end
      DATA: begin
        if (samp) shreg_d = {bit_s, shreg_q[DataBits-1:1]};
        if (last) begin
          if (bitcnt_q == 4'(DataBits - 1))
            state_d = (ParityMode != 0) ? PARITY : STOP1;
          else
            bitcnt_d = bitcnt_q + 4'd1;
        end
      end
      PARITY: begin
        if (samp) begin
          pbit_d = bit_s;
          perr_d = ((^shreg_q) ^ bit_s) != (ParityMode == 2);
        end
        if (last) state_d = STOP1;
      end
      STOP1: begin
        if (samp) begin
          ferr_d = !bit_s;
          // Leave at the sample point so a start edge in the back half of
          // the stop bit is still caught.
          if (StopBits == 1) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end else if (last) begin
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (samp) begin
          ferr_d  = ferr_q | !bit_s;
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign brk = push && (shreg_q == '0) && ferr_d && ((ParityMode == 0) || !pbit_q);
  assign break_det = brk_q;

  // Receive FIFO (first-word-fall-through).
  logic [EW-1:0] mem_q [FifoDepth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          full, pop, wr, ovr_q;

  assign full     = (cnt_q == CW'(FifoDepth));
  assign rx_valid = (cnt_q != '0);
  assign pop      = rx_valid && rx_ready;
  assign wr       = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wptr_q] <= {ferr_d, perr_q, shreg_q};
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (wr && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!wr && pop) cnt_q <= cnt_q - CW'(1);
      if (overrun_clr)                 ovr_q <= 1'b0;
      else if (push && full && !pop)   ovr_q <= 1'b1;
    end
  end

  assign {rx_frame_err, rx_parity_err, rx_data} = mem_q[rptr_q];
  assign fifo_count = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver: configurable frame format, 16x oversampling, runtime baud divisor, and an internal receive FIFO with a valid/ready read port. Each received frame is written to the FIFO together with per-frame error flags. Overrun and break conditions are reported. Sits between the external rx pin and the CPU/MMIO read path, replacing direct buffer writes with a handshaked stream.

Parameters:
ClockFreqHz, 10000000, system clock frequency.
BaudRate, 9600, default baud used when baud_div == 0.
DataBits, 8, data bits per frame; legal 5..9.
ParityMode, 0, 0 = none, 1 = even, 2 = odd.
StopBits, 1, number of stop bits; legal 1 or 2.
FifoDepth, 16, receive FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
rx_sig  in  1  asynchronous serial input; idle high.
baud_div  in  16  clocks per oversample tick; 0 selects ClockFreqHz/(BaudRate*16).
rx_data  out  DataBits  head-of-FIFO data.
rx_parity_err  out  1  head-of-FIFO parity error flag.
rx_frame_err  out  1  head-of-FIFO framing error flag.
rx_valid  out  1  FIFO not empty.
rx_ready  in  1  consumer pop request.
fifo_count  out  $clog2(FifoDepth)+1  current occupancy.
overrun  out  1  sticky; a frame was dropped because the FIFO was full.
overrun_clr  in  1  clears overrun.
break_det  out  1  one-cycle pulse on break frame.

Behaviour:
- Reset values: rx_valid=0, fifo_count=0, overrun=0, break_det=0, rx_data/rx_parity_err/rx_frame_err=0, FSM=IDLE, synchroniser flops=1.
- Reset mid-frame discards the partial frame and empties the FIFO.
- Input: 2-flop synchroniser. All decisions use the synchronised signal.
- Tick generator: counter 0..div-1 produces a 1-cycle tick at wrap. div is latched only in IDLE, so a baud_div change mid-frame takes effect on the next frame.
- Bit timing: 4-bit sample counter counts ticks 0..15 per bit. A bit is sampled at tick 7.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on synchronised 1->0 transition, clear the tick and sample counters and go to START.
- START: at tick 7, if the line is high, return to IDLE (glitch rejection, no FIFO write). Otherwise continue. At tick 15, go to DATA.
- DATA: sample DataBits bits LSB first. After the last bit, go to PARITY if ParityMode != 0, else STOP1.
- PARITY: sample the bit. parity_err = (XOR of data ^ sample) != (ParityMode==2).
- STOP1: sample at tick 7; frame_err = (sample == 0).
  - If StopBits == 2, go to STOP2, which samples the same way and ORs into frame_err.
- End of frame: at the final stop-bit sample, push {frame_err, parity_err, data} and return to IDLE immediately. This allows a start edge in the second half of the stop bit to be caught.
- Break: data all zero, frame_err=1, and parity bit 0 when present -> break_det pulses high for 1 cycle at the same edge as the push.
- FIFO behaviour:
  - First-word-fall-through; rx_valid = (fifo_count != 0).
  - Pop when rx_valid && rx_ready.
  - rx_data and flags update the cycle after a pop.
  - Push to an empty FIFO: rx_valid is high on the next cycle (1-cycle latency).
  - Push when full with no simultaneous pop: frame dropped, overrun <= 1, count unchanged.
  - Push and pop in the same cycle when full: both succeed, no overrun, count unchanged.
  - Read and write pointers wrap modulo FifoDepth.
- overrun_clr has priority over a new overrun in the same cycle.

Optional Feature:
UART_RX_MAJORITY_EN: when defined, each bit (including the start-bit glitch check) is the 2-of-3 majority of samples at ticks 6, 7 and 8. The decision is taken at tick 8. When undefined, a single sample at tick 7 is used. Frame timing and FIFO behaviour are identical in both builds.

Test Plan:
- 8N1, baud_div=4 (64 clk/bit): send 0xA5 -> within 600..620 clk of the start edge, rx_valid=1, rx_data=0xA5, both error flags 0; pop -> fifo_count=0.
- ParityMode=1: send 0x07 with parity bit 0 -> rx_data=0x07, rx_parity_err=1. Send 0x07 with parity bit 1 -> rx_parity_err=0.
- Stop bit held low on 0x3C -> rx_frame_err=1. Send 0x00 with stop low -> break_det pulses for exactly one cycle.
- Glitch: rx_sig low for 20 clk, then high (baud_div=4) -> no push, fifo_count stays 0, FSM back in IDLE.
- FifoDepth=4, rx_ready=0: send 0x11..0x15 -> fifo_count=4, overrun=1, pops return 0x11..0x14 in order; pulse overrun_clr -> overrun=0.
- Assert rst during data bit 3 of a frame -> no push. Next clean frame 0x5A is received correctly; full-FIFO push+pop in the same cycle leaves count at 4 with no overrun.
